// File: rtl/img_pkg.sv
// img_pkg
// Shared pixel and window types for the image pipeline (window generator and
// smoother). A window is a 3x3 neighbourhood per lane, indexed [3*r+c][lane],
// where r=0 is the oldest row and c=0 is the oldest column.
// No ports (package).
package img_pkg;

    localparam int PIX_W   = 8;
    localparam int LANES   = 2;
    localparam int WIN_N   = 9;
    localparam int WIN_DIM = 3;

    typedef logic signed [PIX_W-1:0] pixel_t;
    typedef pixel_t [LANES-1:0] lanes_t;
    typedef pixel_t [WIN_N-1:0][LANES-1:0] window_t;

    // Flat window index for neighbourhood row r (0 = oldest) and column c
    // (0 = oldest).
    function automatic int win_idx(input int r, input int c);
        return WIN_DIM * r + c;
    endfunction

endpackage

// File: rtl/window_generator_if.sv
// window_generator_if
// Streaming pixel-in / window-out bundle of the window generator.
//   pix_in     lanes_t   incoming pixel, one value per lane
//   pix_valid  1         pix_in is accepted on this clock edge
//   window     window_t  3x3 neighbourhood per lane
//   win_valid  1         window holds a complete interior neighbourhood
// modport master: pixel source / window consumer (testbench, upstream stage)
// modport slave:  the window generator itself
interface window_generator_if;
    import img_pkg::*;

    lanes_t  pix_in;
    logic    pix_valid;
    window_t window;
    logic    win_valid;

    modport master (
        output pix_in,
        output pix_valid,
        input  window,
        input  win_valid
    );

    modport slave (
        input  pix_in,
        input  pix_valid,
        output window,
        output win_valid
    );

endinterface

// File: rtl/window_generator_line_buffer.sv
// line_buffer
// One image row of pixels for one lane. Read-before-write at a single
// address: rdata always shows the content stored at addr before the write
// that happens on the enabled clock edge, so the same edge can consume the
// old row value and replace it with the new one. Contents are not reset.
//   clk    input            rising-edge clock
//   en     input            write wdata into addr on this edge
//   addr   input [ADDR_W]   shared read/write address (column)
//   wdata  input pixel_t    value to store
//   rdata  output pixel_t   value stored at addr before this edge's write
module line_buffer
    import img_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  pixel_t            wdata,
    output pixel_t            rdata
);

    pixel_t mem [DEPTH];

    // Combinational read so the window register can take the previous-row
    // pixel on the very edge that accepts the current pixel (1-cycle latency).
    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/window_generator.sv
// window_generator
// Streaming 3x3 window generator. Takes a raster-order stream of two-lane
// signed pixels, keeps the two previous rows in line buffers and emits the
// full 3x3 neighbourhood (window[3*r+c][lane]) with win_valid for every
// interior pixel. One cycle latency, no backpressure, values pass bit-exact.
//
// Parameters:
//   IMG_WIDTH   pixels per row (>= 3)
//   IMG_HEIGHT  rows per frame (>= 3)
// Ports:
//   clk         input   rising-edge clock
//   reset       input   synchronous active-high reset
//   frame_done  output  one-cycle pulse after the last pixel of a frame
//                       (present only when WINGEN_FRAME_DONE_EN is defined)
//   bus         window_generator_if.slave  pix_in/pix_valid in,
//                                          window/win_valid out
// Build option:
//   WINGEN_FRAME_DONE_EN  adds the frame_done port and its register.
module window_generator
    import img_pkg::*;
#(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic clk,
    input  logic reset,
`ifdef WINGEN_FRAME_DONE_EN
    output logic frame_done,
`endif
    window_generator_if.slave bus
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             last_col;
    logic             last_row;
    logic             interior;
    logic             accept;

    lanes_t  lb0_rd;
    lanes_t  lb1_rd;
    window_t win_q;
    window_t win_next;
    logic    win_valid_q;

    assign last_col = (col == COL_W'(IMG_WIDTH - 1));
    assign last_row = (row == ROW_W'(IMG_HEIGHT - 1));
    assign interior = (row >= ROW_W'(2)) && (col >= COL_W'(2));

    // Reset overrides pix_valid, so nothing (not even the line buffers) is
    // advanced on a reset edge.
    assign accept = bus.pix_valid && !reset;

    // Raster position of the pixel currently offered on pix_in.
    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (bus.pix_valid) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // lb0 holds row r-1, lb1 holds row r-2. Accepting a pixel moves the old
    // lb0 entry down into lb1 and stores the new pixel in lb0.
    for (genvar lane = 0; lane < LANES; lane++) begin : g_lane
        line_buffer #(
            .DEPTH  (IMG_WIDTH),
            .ADDR_W (COL_W)
        ) u_lb0 (
            .clk   (clk),
            .en    (accept),
            .addr  (col),
            .wdata (bus.pix_in[lane]),
            .rdata (lb0_rd[lane])
        );

        line_buffer #(
            .DEPTH  (IMG_WIDTH),
            .ADDR_W (COL_W)
        ) u_lb1 (
            .clk   (clk),
            .en    (accept),
            .addr  (col),
            .wdata (lb0_rd[lane]),
            .rdata (lb1_rd[lane])
        );
    end

    // Every window row shifts one column towards the old side; the new
    // column is (row r-2, row r-1, current pixel) top to bottom.
    always_comb begin
        win_next = win_q;
        for (int r = 0; r < WIN_DIM; r++) begin
            for (int c = 0; c < WIN_DIM - 1; c++) begin
                win_next[win_idx(r, c)] = win_q[win_idx(r, c + 1)];
            end
        end
        win_next[win_idx(0, 2)] = lb1_rd;
        win_next[win_idx(1, 2)] = lb0_rd;
        win_next[win_idx(2, 2)] = bus.pix_in;
    end

    // The window keeps shifting on border pixels so stale columns from the
    // previous row are flushed out before the first interior pixel (col 2).
    always_ff @(posedge clk) begin
        if (reset) begin
            win_q       <= '0;
            win_valid_q <= 1'b0;
        end else begin
            win_valid_q <= bus.pix_valid && interior;
            if (bus.pix_valid) begin
                win_q <= win_next;
            end
        end
    end

    assign bus.window    = win_q;
    assign bus.win_valid = win_valid_q;

`ifdef WINGEN_FRAME_DONE_EN
    // Registered alongside win_valid so it lines up with the frame's last
    // window.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= bus.pix_valid && last_col && last_row;
        end
    end
`endif

endmodule
